// File: rtl/ext_databus_arbiter.sv
// ext_databus_arbiter
//
// Round-robin arbiter that shares one external databus master port among N_REQ DMA-style
// requester channels. A channel holds req_valid high for a whole transfer; the arbiter locks
// the grant for that transfer and, when MAX_BURST is non-zero, preempts a long burst after
// MAX_BURST accepted beats if another channel is waiting. There is no data buffering: the
// request/response path is a pure mux driven from the registered grant.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   req_valid  per-channel request valid (held for the whole transfer)
//   req_addr   per-channel address, channel i at [i*ADDR_W +: ADDR_W]
//   req_wdata  per-channel write data, channel i at [i*DATA_W +: DATA_W]
//   req_wstrb  per-channel write strobes (all zero = read)
//   req_ready  per-channel ready, only the granted bit can be high
//   req_rdata  read data broadcast to all channels
//   m_valid / m_addr / m_wdata / m_wstrb  master port request
//   m_ready / m_rdata                     master port ready / read data
//   grant      registered one-hot grant (zero when idle)
//   busy       high while a channel is granted
module ext_databus_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ADDR_W-1:0]    req_addr,
  input  logic [N_REQ*DATA_W-1:0]    req_wdata,
  input  logic [N_REQ*DATA_W/8-1:0]  req_wstrb,
  output logic [N_REQ-1:0]           req_ready,
  output logic [DATA_W-1:0]          req_rdata,
  output logic                       m_valid,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic                       m_ready,
  input  logic [DATA_W-1:0]          m_rdata,
  output logic [N_REQ-1:0]           grant,
  output logic                       busy
);

  localparam int unsigned IdxW  = $clog2(N_REQ);
  localparam int unsigned StrbW = DATA_W / 8;
  // A zero-width counter is illegal, so MAX_BURST = 0 still gets one (unused) bit.
  localparam int unsigned CntW  = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

  // Two-bit encoding leaves spare codes; any of them falls back to idle.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGrant = 2'b01
  } state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0]   last_idx_q, last_idx_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;
  int unsigned       cand;
  logic              others_valid;

  // Round-robin pick: first requester searching upward from last_idx + 1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = (32'(last_idx_q) + i) % N_REQ;
      if (!pick_found && req_valid[IdxW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  assign others_valid = |(req_valid & ~grant_q);
  assign req_rdata    = m_rdata;
  assign grant        = grant_q;

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    m_valid    = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_wstrb    = '0;
    req_ready  = '0;
    busy       = 1'b0;

    case (state_q)
      StIdle: begin
        grant_d = '0;
        if (pick_found) begin
          gnt_idx_d          = pick_idx;
          grant_d[pick_idx]  = 1'b1;
          beat_cnt_d         = '0;
          state_d            = StGrant;
        end
      end

      StGrant: begin
        busy                 = 1'b1;
        m_valid              = req_valid[gnt_idx_q];
        m_addr               = req_addr[gnt_idx_q*ADDR_W +: ADDR_W];
        m_wdata              = req_wdata[gnt_idx_q*DATA_W +: DATA_W];
        m_wstrb              = req_wstrb[gnt_idx_q*StrbW +: StrbW];
        req_ready[gnt_idx_q] = m_ready;

        if (!req_valid[gnt_idx_q]) begin
          state_d    = StIdle;
          last_idx_d = gnt_idx_q;
          grant_d    = '0;
        end else if (m_ready) begin
          // Saturating beat count; once at the limit, the next accepted beat with a
          // competitor waiting ends the grant.
          if (beat_cnt_q != CntW'(MAX_BURST)) begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
          if ((MAX_BURST != 0) && (beat_cnt_d == CntW'(MAX_BURST)) && others_valid) begin
            state_d    = StIdle;
            last_idx_d = gnt_idx_q;
            grant_d    = '0;
          end
        end
      end

      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      gnt_idx_q  <= '0;
      last_idx_q <= IdxW'(N_REQ - 1);
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_databus_arbiter.sv
module tb_ext_databus_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*SW-1:0]   req_wstrb;
  logic              m_ready;
  logic [DW-1:0]     m_rdata;

  // dut: MAX_BURST = 4, dut0: MAX_BURST = 0 (preemption disabled); same inputs.
  logic [N-1:0]      a_req_ready, b_req_ready;
  logic [DW-1:0]     a_req_rdata, b_req_rdata;
  logic              a_m_valid, b_m_valid;
  logic [AW-1:0]     a_m_addr, b_m_addr;
  logic [DW-1:0]     a_m_wdata, b_m_wdata;
  logic [SW-1:0]     a_m_wstrb, b_m_wstrb;
  logic [N-1:0]      a_grant, b_grant;
  logic              a_busy, b_busy;

  always #5 clk = ~clk;

  ext_databus_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(a_req_ready),
    .req_rdata(a_req_rdata), .m_valid(a_m_valid), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_wstrb(a_m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .grant(a_grant), .busy(a_busy)
  );

  ext_databus_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(b_req_ready),
    .req_rdata(b_req_rdata), .m_valid(b_m_valid), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_wstrb(b_m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .grant(b_grant), .busy(b_busy)
  );

  logic          sel0;
  logic          mon_mv;
  logic [N-1:0]  mon_ready;
  logic [AW-1:0] mon_addr;
  logic [DW-1:0] mon_wdata;
  assign mon_mv    = sel0 ? b_m_valid   : a_m_valid;
  assign mon_ready = sel0 ? b_req_ready : a_req_ready;
  assign mon_addr  = sel0 ? b_m_addr    : a_m_addr;
  assign mon_wdata = sel0 ? b_m_wdata   : a_m_wdata;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] base(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [31:0] wdat(input int i, input int k);
    return 32'hD000_0000 + (32'(i) << 16) + 32'(k);
  endfunction

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [3:0]  rv;
    logic        mr;
    logic [3:0]  gnt;
    logic        mv;
    logic [3:0]  rdy;
    logic        bsy;
    logic [31:0] addr;
    logic [3:0]  strb;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [3:0] rv, input logic mr, input logic [3:0] gnt,
                         input logic mv, input logic [3:0] rdy, input logic bsy,
                         input logic [31:0] addr, input logic [3:0] strb);
    vec_t v;
    v.rv = rv; v.mr = mr; v.gnt = gnt; v.mv = mv; v.rdy = rdy; v.bsy = bsy;
    v.addr = addr; v.strb = strb;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard model ----------------
  typedef struct { int ch; logic [31:0] addr; int cyc; } exp_t;
  typedef struct { int cyc; int ch; int n; } ev_t;
  exp_t sb[$];
  ev_t  evs[$];
  int   rem[N];
  int   done[N];
  int   exp_cnt[N];
  int   cur;

  task automatic push_exp(input int ch, input int cyc);
    exp_t e;
    e.ch   = ch;
    e.addr = base(ch) + 32'(exp_cnt[ch]) * 4;
    e.cyc  = cyc;
    exp_cnt[ch]++;
    sb.push_back(e);
  endtask

  task automatic add_ev(input int cyc, input int ch, input int n);
    ev_t e;
    e.cyc = cyc; e.ch = ch; e.n = n;
    evs.push_back(e);
  endtask

  task automatic drive_fields();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = base(i) + 32'(done[i]) * 4;
      req_wdata[i*DW +: DW] = wdat(i, done[i]);
      req_wstrb[i*SW +: SW] = '0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0; done[i] = 0; exp_cnt[i] = 0;
    end
    sb.delete();
    evs.delete();
    drive_fields();
    @(negedge clk);
    rst = 1'b1;
    cur = 0;
  endtask

  task automatic run_cycles(input int ncyc);
    exp_t e;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      foreach (evs[k]) if (evs[k].cyc == cur) rem[evs[k].ch] = evs[k].n;
      for (int i = 0; i < N; i++) req_valid[i] = (rem[i] > 0);
      drive_fields();
      m_ready = 1'b1;
      m_rdata = $urandom;
      #1;
      chk($sformatf("c%0d ready_onehot", cur), 32'($countones(mon_ready) <= 1), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (mon_ready[i] && mon_mv) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got channel %0d at cycle %0d, expected none", i,
                     cur);
          end else begin
            e = sb.pop_front();
            chk($sformatf("c%0d beat_ch", cur), i, e.ch);
            chk($sformatf("c%0d beat_cyc", cur), cur, e.cyc);
            chk($sformatf("c%0d beat_addr", cur), mon_addr, e.addr);
            chk($sformatf("c%0d beat_wdata", cur), mon_wdata, wdat(i, done[i]));
          end
          done[i]++;
          rem[i]--;
        end
      end
      cur++;
    end
  endtask

  initial begin
    sel0      = 1'b0;
    req_valid = 4'hF;
    m_ready   = 1'b1;
    m_rdata   = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    // Reset state, even with every channel requesting.
    repeat (2) @(negedge clk);
    #1;
    chk("rst grant", a_grant, 0);
    chk("rst busy", a_busy, 0);
    chk("rst m_valid", a_m_valid, 0);
    chk("rst req_ready", a_req_ready, 0);
    chk("rst grant0", b_grant, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;

    // Table phase: fixed per-channel fields, channel 3 writes with full strobes.
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = base(i);
      req_wdata[i*DW +: DW] = wdat(i, 0);
      req_wstrb[i*SW +: SW] = (i == 3) ? 4'hF : 4'h0;
    end
    // single channel 1, five beats, then release
    add_vec(4'h2, 1, 4'h0, 0, 4'h0, 0, 32'h0, 4'h0);
    for (int k = 0; k < 5; k++) add_vec(4'h2, 1, 4'h2, 1, 4'h2, 1, base(1), 4'h0);
    add_vec(4'h0, 0, 4'h2, 0, 4'h0, 1, base(1), 4'h0);
    add_vec(4'h0, 0, 4'h0, 0, 4'h0, 0, 32'h0, 4'h0);
    // channel 3 write under backpressure, channel 0 waiting -> preempt after 4 ready beats
    add_vec(4'h8, 0, 4'h0, 0, 4'h0, 0, 32'h0, 4'h0);
    add_vec(4'h9, 1, 4'h8, 1, 4'h8, 1, base(3), 4'hF);
    add_vec(4'h9, 0, 4'h8, 1, 4'h0, 1, base(3), 4'hF);
    add_vec(4'h9, 0, 4'h8, 1, 4'h0, 1, base(3), 4'hF);
    add_vec(4'h9, 1, 4'h8, 1, 4'h8, 1, base(3), 4'hF);
    add_vec(4'h9, 0, 4'h8, 1, 4'h0, 1, base(3), 4'hF);
    add_vec(4'h9, 1, 4'h8, 1, 4'h8, 1, base(3), 4'hF);
    add_vec(4'h9, 1, 4'h8, 1, 4'h8, 1, base(3), 4'hF);
    add_vec(4'h9, 1, 4'h0, 0, 4'h0, 0, 32'h0, 4'h0);
    add_vec(4'h9, 0, 4'h1, 1, 4'h0, 1, base(0), 4'h0);
    add_vec(4'h0, 0, 4'h1, 0, 4'h0, 1, base(0), 4'h0);
    add_vec(4'h0, 0, 4'h0, 0, 4'h0, 0, 32'h0, 4'h0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      req_valid = vecs[k].rv;
      m_ready   = vecs[k].mr;
      m_rdata   = $urandom;
      #1;
      chk($sformatf("v%0d grant", k), a_grant, vecs[k].gnt);
      chk($sformatf("v%0d m_valid", k), a_m_valid, vecs[k].mv);
      chk($sformatf("v%0d req_ready", k), a_req_ready, vecs[k].rdy);
      chk($sformatf("v%0d busy", k), a_busy, vecs[k].bsy);
      chk($sformatf("v%0d m_addr", k), a_m_addr, vecs[k].addr);
      chk($sformatf("v%0d m_wstrb", k), a_m_wstrb, vecs[k].strb);
      chk($sformatf("v%0d req_rdata", k), a_req_rdata, m_rdata);
    end

    // Round robin: all four request 2 beats, twice; order 0..3 both rounds.
    do_reset();
    for (int i = 0; i < N; i++) begin
      add_ev(0, i, 2);
      add_ev(16, i, 2);
    end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        push_exp(i, 16 * r + 1 + 4 * i);
        push_exp(i, 16 * r + 2 + 4 * i);
      end
    run_cycles(34);
    chk("rr sb_empty", sb.size(), 0);

    // Preemption at 4 beats: ch0 10 beats, ch2 3 beats from cycle 2.
    do_reset();
    add_ev(0, 0, 10);
    add_ev(2, 2, 3);
    for (int k = 1; k <= 4; k++) push_exp(0, k);
    for (int k = 6; k <= 8; k++) push_exp(2, k);
    for (int k = 11; k <= 16; k++) push_exp(0, k);
    run_cycles(20);
    chk("pre sb_empty", sb.size(), 0);

    // Reset during the third beat of channel 1.
    do_reset();
    add_ev(0, 1, 6);
    push_exp(1, 1);
    push_exp(1, 2);
    run_cycles(3);
    @(negedge clk);
    drive_fields();
    req_valid = 4'h2;
    #1;
    chk("mid m_valid_before", a_m_valid, 1);
    chk("mid grant_before", a_grant, 4'h2);
    rst = 1'b0;
    #1;
    chk("mid grant", a_grant, 0);
    chk("mid busy", a_busy, 0);
    chk("mid m_valid", a_m_valid, 0);
    chk("mid req_ready", a_req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid sb_empty", sb.size(), 0);
    evs.delete();
    cur = 0;
    add_ev(0, 0, 1);
    push_exp(0, 1);
    for (int k = 4; k <= 7; k++) push_exp(1, k);
    run_cycles(10);
    chk("mid2 sb_empty", sb.size(), 0);

    // MAX_BURST = 0: 200 beats with no preemption, competitor only after release.
    sel0 = 1'b1;
    do_reset();
    add_ev(0, 0, 200);
    add_ev(10, 1, 1);
    for (int k = 1; k <= 200; k++) push_exp(0, k);
    push_exp(1, 203);
    run_cycles(206);
    chk("nopre sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ext_databus_arbiter.md
# ext_databus_arbiter

Round-robin arbiter that shares one external databus port among N_REQ external address-generator channels. Each channel is a read or write DMA requester that holds its valid high for a whole transfer. The arbiter locks a grant for that transfer and optionally preempts long bursts so other channels are not starved. It sits between the Versat external-memory channels and the system databus master port, and has no internal data buffering.

## Interface
Parameters:
- N_REQ, 4: number of requester channels (2..16).
- DATA_W, 32: databus data width.
- ADDR_W, 32: databus address width (`IO_ADDR_W` in the system).
- MAX_BURST, 64: accepted beats after which the arbiter preempts if another channel is waiting. 0 disables preemption.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-channel request valid; held high for the whole transfer.
- req_addr  in  N_REQ*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  per-channel write data.
- req_wstrb  in  N_REQ*DATA_W/8  per-channel write strobes; all zero means a read.
- req_ready  out  N_REQ  per-channel ready; only the granted bit may be high.
- req_rdata  out  DATA_W  read data, broadcast to all channels (equals m_rdata).
- m_valid  out  1  master port valid.
- m_addr  out  ADDR_W  master port address.
- m_wdata  out  DATA_W  master port write data.
- m_wstrb  out  DATA_W/8  master port write strobes.
- m_ready  in  1  master port ready / read data valid.
- m_rdata  in  DATA_W  master port read data.
- grant  out  N_REQ  one-hot registered grant; all zero when no channel is granted.
- busy  out  1  high while in the GRANT state.

## Operation
State machine with two states, IDLE and GRANT, plus the registers gnt_idx, last_idx and beat_cnt.

- **Reset:** state = IDLE, grant = 0, last_idx = N_REQ-1 (channel 0 has first priority), beat_cnt = 0.
- **IDLE:**
  - All master outputs and req_ready are driven to 0.
  - If any req_valid is high, select the first set bit searching from last_idx+1 upward, wrapping modulo N_REQ.
  - Register gnt_idx and the one-hot grant, clear beat_cnt, then move to GRANT.
- **GRANT, combinational path:** m_valid = req_valid[g], m_addr/m_wdata/m_wstrb = channel g's fields, req_ready[g] = m_ready. All other req_ready bits are 0.
- **Beat counting:** every cycle with m_valid & m_ready increments beat_cnt. The counter is $clog2(MAX_BURST+1) bits wide and saturates.
- **Release on drop:** if req_valid[g] is low, m_valid is 0 that cycle. The next state is IDLE, last_idx = g, grant = 0.
- **Preemption:** if MAX_BURST≠0, an accepted beat makes beat_cnt reach MAX_BURST, and any other req_valid is high, the arbiter goes to IDLE after that beat and sets last_idx = g. The preempted channel keeps valid high. It stalls on req_ready = 0 and is re-granted in round-robin order.
- **No competitor at limit:** if beat_cnt reaches MAX_BURST and no other channel is requesting, the grant is kept and beat_cnt stays saturated. Preemption triggers on the first accepted beat after a competitor appears.
- **Data path:** there are no transaction IDs. Read data is valid on the cycle m_ready is high, and only the granted channel's req_ready qualifies it.

## Timing
- **Arbitration latency:** req_valid rising in IDLE gives grant and m_valid on the next cycle, i.e. 1 cycle.
- **Throughput:** 1 beat per cycle while m_ready is high. Every grant switch costs exactly 1 idle cycle (IDLE), during which m_valid = 0.
- **Combinational paths:** req_ready, m_valid and the data/address muxes are combinational from the registered grant. m_ready to req_ready is combinational (zero latency).
- **Simultaneous requests:** in IDLE, the lowest index at or after last_idx+1, modulo N_REQ, wins.
- **Drop and new request together:** if req_valid[g] drops in the same cycle another channel raises, go to IDLE first. The new channel is granted on the following edge.
- **Reset mid-transfer:** grant, busy, m_valid and req_ready go to 0 immediately (asynchronous). The in-flight beat is abandoned.
- **Illegal states:** an unused state encoding returns to IDLE.

## Test plan
- **Single channel:** reset, then req_valid[1] = 1 for 5 beats with m_ready = 1 -> grant = 4'b0010 one cycle later, 5 beats with m_addr = req_addr[1], release to IDLE when valid drops, grant = 0.
- **Round-robin:** all four channels request 2-beat transfers at once -> grant order 0,1,2,3, with one IDLE cycle between each. Repeat -> order restarts at 0.
- **Preemption:** MAX_BURST = 4, channel 0 requests 10 beats, channel 2 requests from cycle 2 -> channel 0 gets 4 beats, 1 IDLE cycle, channel 2 served, then channel 0 resumes and completes its remaining 6 beats.
- **Backpressure:** channel 3 writing with wstrb = 4'hF, m_ready toggling 1,0,0,1 -> req_ready[3] mirrors m_ready, beat_cnt advances only on ready cycles, and other req_ready bits stay 0.
- **Reset mid-burst:** assert rst = 0 during the 3rd beat of channel 1 -> m_valid, grant and busy drop in the same cycle. After release, channel 0 has priority.
- **No competitor at limit:** MAX_BURST = 0, channel 0 requests 200 beats while channel 1 is idle -> no preemption and no IDLE gap.
